// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue: fetch front end ahead of IF/ID.
// Fetches 16-bit words over a req/ack handshake into a small circular FIFO
// tagged with PC+2; a redirect flushes the queue and drops any in-flight fetch.
// Optional: define IPQ_STATS_EN to add the discard_count statistics output.
module instruction_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  input  logic                       stall,
  output logic                       imem_req,
  output logic [15:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [15:0]                imem_rdata,
  output logic                       inst_valid,
  output logic [15:0]                inst,
  output logic [15:0]                inst_pc_plus2,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
`ifdef IPQ_STATS_EN
  ,
  output logic [15:0]                discard_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc2;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [15:0]     fetch_pc, fetch_pc_n;
  logic [15:0]     req_addr, req_addr_n;
  state_t          state, state_n;
  logic            push, pop, drop;

  // FIFO handshake terms; redirect wins over both push and pop
  assign pop  = inst_valid & ~stall & ~redirect;
  assign push = (state == FETCH) & imem_ack & ~redirect;

  // occupancy after this edge, used by the FSM to decide whether to request
  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else
      count_next = count + CW'(push) - CW'(pop);
  end

  // queue head and memory interface outputs
  assign inst_valid    = (count != '0);
  assign inst          = inst_valid ? mem[rd_ptr].word : 16'h0000;
  assign inst_pc_plus2 = inst_valid ? mem[rd_ptr].pc2  : 16'h0000;
  assign queue_count   = count;
  assign imem_req      = (state != IDLE);
  assign imem_addr     = req_addr;

  // FIFO storage; entries need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{word: imem_rdata, pc2: req_addr + 16'd2};
  end

  // FIFO pointers and occupancy; a flush collapses rd_ptr onto wr_ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (redirect) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  // fetch FSM state and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
    end
  end

  // fetch FSM next-state: keep one request in flight while there is room
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
        end else if (count_next < DEPTH_C) begin
          req_addr_n = fetch_pc;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          if (imem_ack) begin
            drop    = 1'b1;
            state_n = IDLE;
          end else begin
            // memory still owes us a word at req_addr; swallow it first
            state_n = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_n = fetch_pc + 16'd2;
          if (count_next < DEPTH_C)
            req_addr_n = fetch_pc + 16'd2;
          else
            state_n = IDLE;
        end
      end
      DISCARD: begin
        if (redirect)
          fetch_pc_n = redirect_pc;
        if (imem_ack) begin
          drop    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IPQ_STATS_EN
  logic [16:0] discard_sum;

  always_comb begin
    discard_sum = {1'b0, discard_count}
                + (redirect ? 17'(count) : 17'd0)
                + 17'(drop);
  end

  // saturating count of flushed entries plus dropped fetch words
  always_ff @(posedge clk) begin
    if (rst)
      discard_count <= 16'h0000;
    else if (discard_sum[16])
      discard_count <= 16'hFFFF;
    else
      discard_count <= discard_sum[15:0];
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue. Inputs change and outputs are
// sampled on the falling edge. Memory returns addr+0x1000 as instruction data.
module tb_instruction_prefetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // DUT 0: default parameters
  logic        rst0 = 1'b1, redir0 = 1'b0, stall0 = 1'b0, ack_en0 = 1'b1;
  logic [15:0] rpc0 = 16'h0000;
  logic        req0, ack0, vld0;
  logic [15:0] addr0, rdata0, inst0, pc20;
  logic [2:0]  cnt0;
`ifdef IPQ_STATS_EN
  logic [15:0] dc0;
`endif

  assign ack0   = req0 & ack_en0;
  assign rdata0 = addr0 + 16'h1000;

  instruction_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst0), .redirect(redir0), .redirect_pc(rpc0), .stall(stall0),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_rdata(rdata0),
    .inst_valid(vld0), .inst(inst0), .inst_pc_plus2(pc20), .queue_count(cnt0)
`ifdef IPQ_STATS_EN
    , .discard_count(dc0)
`endif
  );

  // DUT 1: reset PC near the top of the address space
  logic        rst1 = 1'b1;
  logic        req1, ack1, vld1;
  logic [15:0] addr1, rdata1, inst1, pc21;
  logic [2:0]  cnt1;
`ifdef IPQ_STATS_EN
  logic [15:0] dc1;
`endif

  assign ack1   = req1;
  assign rdata1 = addr1 + 16'h1000;

  instruction_prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFC)) dut1 (
    .clk(clk), .rst(rst1), .redirect(1'b0), .redirect_pc(16'h0000), .stall(1'b0),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .inst_valid(vld1), .inst(inst1), .inst_pc_plus2(pc21), .queue_count(cnt1)
`ifdef IPQ_STATS_EN
    , .discard_count(dc1)
`endif
  );

  task automatic reset0();
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  initial begin
    // ---- reset values and basic streaming ----
    reset0();
    chk("rst_req",   32'(req0),  32'd0);
    chk("rst_valid", 32'(vld0),  32'd0);
    chk("rst_inst",  32'(inst0), 32'h0);
    chk("rst_pc2",   32'(pc20),  32'h0);
    chk("rst_count", 32'(cnt0),  32'd0);
    @(negedge clk);
    chk("s_req1",  32'(req0),  32'd1);
    chk("s_addr1", 32'(addr0), 32'h0000);
    chk("s_vld1",  32'(vld0),  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s_vld",  32'(vld0),  32'd1);
      chk("s_inst", 32'(inst0), 32'(16'h1000 + 16'(2*i)));
      chk("s_pc2",  32'(pc20),  32'(16'(2*i + 2)));
    end

    // ---- fill to full under stall, then drain ----
    stall0 = 1'b1;
    reset0();
    repeat (8) @(negedge clk);
    chk("full_count", 32'(cnt0),  32'd4);
    chk("full_req",   32'(req0),  32'd0);
    chk("full_head",  32'(inst0), 32'h1000);
    stall0 = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(cnt0),  32'd3);
    chk("drain_req",   32'(req0),  32'd1);
    chk("drain_addr",  32'(addr0), 32'h0008);
    chk("drain_inst0", 32'(inst0), 32'h1002);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_inst", 32'(inst0), 32'(16'h1000 + 16'(2*i)));
    end

    // ---- redirect during a withheld fetch with 3 entries queued ----
    stall0 = 1'b1;
    reset0();
    repeat (4) @(negedge clk);
    ack_en0 = 1'b0;
    @(negedge clk);
    chk("rd_pre_count", 32'(cnt0),  32'd3);
    chk("rd_pre_addr",  32'(addr0), 32'h0006);
    redir0 = 1'b1;
    rpc0   = 16'h0040;
    @(negedge clk);
    redir0 = 1'b0;
    chk("rd_count0", 32'(cnt0),  32'd0);
    chk("rd_vld0",   32'(vld0),  32'd0);
    chk("rd_req",    32'(req0),  32'd1);
    chk("rd_hold1",  32'(addr0), 32'h0006);
    @(negedge clk);
    chk("rd_hold2",  32'(addr0), 32'h0006);
    ack_en0 = 1'b1;
    @(negedge clk);
    chk("rd_dropreq", 32'(req0), 32'd0);
    chk("rd_dropcnt", 32'(cnt0), 32'd0);
`ifdef IPQ_STATS_EN
    chk("rd_stats", 32'(dc0), 32'd4);
`endif
    @(negedge clk);
    chk("rd_newaddr", 32'(addr0), 32'h0040);
    chk("rd_newreq",  32'(req0),  32'd1);
    @(negedge clk);
    chk("rd_newinst", 32'(inst0), 32'h1040);
    chk("rd_newpc2",  32'(pc20),  32'h0042);

    // ---- redirect coincident with a pop and an ack ----
    stall0 = 1'b0;
    redir0 = 1'b1;
    rpc0   = 16'h0080;
    @(negedge clk);
    redir0 = 1'b0;
    chk("rp_vld",   32'(vld0),  32'd0);
    chk("rp_inst",  32'(inst0), 32'h0);
    chk("rp_count", 32'(cnt0),  32'd0);
    chk("rp_req",   32'(req0),  32'd0);
`ifdef IPQ_STATS_EN
    chk("rp_stats", 32'(dc0), 32'd6);
`endif
    @(negedge clk);
    chk("rp_addr", 32'(addr0), 32'h0080);
    @(negedge clk);
    chk("rp_inst2", 32'(inst0), 32'h1080);
    chk("rp_pc2",   32'(pc20),  32'h0082);

    // ---- reset during an outstanding request with 2 entries ----
    stall0 = 1'b1;
    reset0();
    repeat (3) @(negedge clk);
    ack_en0 = 1'b0;
    @(negedge clk);
    chk("mr_count", 32'(cnt0), 32'd2);
    chk("mr_req",   32'(req0), 32'd1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    ack_en0 = 1'b1;
    chk("mr_rreq",   32'(req0),  32'd0);
    chk("mr_rvld",   32'(vld0),  32'd0);
    chk("mr_rinst",  32'(inst0), 32'h0);
    chk("mr_rpc2",   32'(pc20),  32'h0);
    chk("mr_rcount", 32'(cnt0),  32'd0);
`ifdef IPQ_STATS_EN
    chk("mr_rstats", 32'(dc0), 32'd0);
`endif
    @(negedge clk);
    chk("mr_addr", 32'(addr0), 32'h0000);
    chk("mr_req2", 32'(req0),  32'd1);

    // ---- 16-bit PC wrap on the second instance ----
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    chk("w_addr0", 32'(addr1), 32'hFFFC);
    @(negedge clk);
    chk("w_addr1", 32'(addr1), 32'hFFFE);
    chk("w_inst0", 32'(inst1), 32'h0FFC);
    chk("w_pc20",  32'(pc21),  32'hFFFE);
    @(negedge clk);
    chk("w_addr2", 32'(addr1), 32'h0000);
    chk("w_inst1", 32'(inst1), 32'h0FFE);
    chk("w_pc21",  32'(pc21),  32'h0000);
    @(negedge clk);
    chk("w_inst2", 32'(inst1), 32'h1000);
    chk("w_pc22",  32'(pc21),  32'h0002);
    chk("w_vld",   32'(vld1),  32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
Fetch-side front end that sits directly upstream of the IF/ID pipeline buffer. It fetches 16-bit instructions from a multi-cycle instruction memory over a req/ack handshake and buffers them, tagged with PC+2, in a small FIFO. Decode consumes one entry per cycle unless stalled. A taken branch in ID redirects the queue, which flushes all buffered entries and drops any in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries; a power of two, at least 2
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
redirect  input  1  taken branch/redirect from ID; flushes the queue
redirect_pc  input  16  new fetch address, sampled when redirect=1
stall  input  1  decode cannot accept this cycle (hazard/buffer halt)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  fetch address; stable while imem_req=1
imem_ack  input  1  memory returns data this cycle; valid only while imem_req=1
imem_rdata  input  16  instruction word, valid with imem_ack
inst_valid  output  1  head entry valid
inst  output  16  head instruction; 16'h0000 (NOP) when inst_valid=0
inst_pc_plus2  output  16  head entry's fetch address + 2; 16'h0000 when inst_valid=0
queue_count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (synchronous, rst=1 at the edge): rd_ptr=wr_ptr=0, count=0, fetch_pc=RESET_PC, req_addr=RESET_PC, state=IDLE. Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc_plus2=0, queue_count=0. Reset asserted mid-transaction abandons the transaction; the memory must tolerate the req drop.
- FIFO: circular, pointers wrap modulo DEPTH. inst_valid = (count!=0). inst and inst_pc_plus2 are read combinationally from the head entry.
- Pop: occurs when inst_valid & ~stall & ~redirect.
- Push: occurs when state=FETCH & imem_ack & ~redirect. Writes {imem_rdata, req_addr+2}.
- Push and pop in the same cycle leave count unchanged. A push is never attempted while full; this is guaranteed by the FSM.
- FSM states: IDLE, FETCH, DISCARD. imem_req = (state!=IDLE). imem_addr = req_addr.
- IDLE:
  - If redirect: fetch_pc <= redirect_pc.
  - Else if count_next < DEPTH: req_addr <= fetch_pc, go to FETCH.
- FETCH:
  - redirect & imem_ack: data dropped; fetch_pc <= redirect_pc; go to IDLE.
  - redirect & ~imem_ack: fetch_pc <= redirect_pc; go to DISCARD; req_addr is held.
  - imem_ack, no redirect: push; fetch_pc <= fetch_pc+2.
    - If count_next < DEPTH: req_addr <= fetch_pc+2 and stay in FETCH. This gives back-to-back requests at one instruction per cycle.
    - Otherwise go to IDLE.
  - No ack: hold all state.
- DISCARD: imem_req stays 1 at the old address until imem_ack. On ack, data is dropped and the FSM goes to IDLE. A further redirect while in DISCARD only updates fetch_pc.
- Redirect: flushes the queue (rd_ptr=wr_ptr, count=0) at the same edge. Redirect has priority over a simultaneous pop or push. The first instruction from redirect_pc is visible no earlier than 2 cycles after redirect, assuming a zero-wait ack.
- Latency: with ack returned in the same cycle as req, the instruction at RESET_PC is valid on the 2nd cycle after rst deasserts.
- Arithmetic: all PC arithmetic is 16-bit modulo. fetch_pc 16'hFFFE + 2 wraps to 16'h0000, and the tag of that entry is 16'h0000.
- Full: no request is issued while full. A pop from a full queue lets IDLE start a new request in the same cycle (count_next < DEPTH).

Optional Feature:
IPQ_STATS_EN: when defined, adds output discard_count[15:0]. The counter resets to 0 and adds, per cycle, the number of valid entries flushed by redirect plus 1 for each fetch data word dropped (DISCARD ack, or FETCH ack coincident with redirect). It saturates at 16'hFFFF. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, ack same cycle, stall=0 -> inst at 0x0000, 0x0002, 0x0004 on consecutive cycles from the 2nd cycle; inst_pc_plus2 = 0x0002, 0x0004, 0x0006.
- stall=1 held with ack every cycle, DEPTH=4 -> queue_count reaches 4, imem_req drops to 0; release stall -> 4 entries drain in order, fetching resumes at 0x0008.
- Queue holding 3 entries and a fetch stalled (ack withheld) -> redirect with redirect_pc=0x0040 -> count 0 next cycle, imem_addr held at the old address until ack, old data dropped, next request at 0x0040; with IPQ_STATS_EN, discard_count=4.
- Redirect and pop in the same cycle -> no pop; queue empty; inst=0x0000, inst_valid=0.
- RESET_PC=16'hFFFC, fetch 3 words -> addresses FFFC, FFFE, 0000; tags FFFE, 0000, 0002.
- rst asserted for one cycle during an outstanding request with 2 entries queued -> next cycle all outputs at reset values, fetch restarts at RESET_PC.
